bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential double-dabble converter: a binary count (0..9999 nominal) becomes packed BCD digits.
//  Sits directly upstream of the 4-digit 7-segment scanner and drives its per-digit nibbles.
//  Replaces the combinational /1000 %100 /10 dividers with an iterative shift/add-3 datapath.
//  Uses a start/busy/done handshake. Results are registered and held until the next conversion completes.
// PARAMETERS
//  BIN_W  14  width of the binary input
//  N_DIG   4  number of BCD output digits; max representable value MAX_VAL = 10**N_DIG-1
// PORTS
//  CLK100MHz  in   1        system clock, 100 MHz; the only clock
//  RST        in   1        reset: synchronous, active-high
//  Start      in   1        request a conversion; sampled only when Busy==0
//  Bin        in   BIN_W    binary value; captured on the accepted Start edge only
//  Busy       out  1        high while a conversion is in flight
//  Done       out  1        one-cycle pulse: BCD and Ovf are updated this cycle
//  Ovf        out  1        captured Bin > MAX_VAL; valid with Done, held until the next Done
//  BCD        out  4*N_DIG  packed digits, [3:0] = ones, [15:12] = thousands (N_DIG=4)
// BEHAVIOUR
//  Reset (RST==1 at an edge) forces the following, regardless of state:
//   - state IDLE
//   - Busy=0, Done=0, Ovf=0, BCD=0
//   - internal shift registers cleared
//  Reset during SHIFT aborts the conversion: no Done, outputs read 0.
//  FSM: IDLE -> SHIFT -> FINISH -> IDLE.
//   - IDLE: Start==1 at edge k captures Bin into shreg, clears the BCD accumulator, loads iter=BIN_W-1, goes to SHIFT. Busy=1 from k+1.
//   - SHIFT: each edge first adds 3 to every accumulator digit >=5, then shifts {acc,shreg} left by 1.
//     Decrements iter; leaves SHIFT after BIN_W shifts (edges k+1..k+BIN_W).
//   - FINISH (edge k+BIN_W+1): BCD<=result, Ovf<=flag, Done=1 for this one cycle, Busy=0, return to IDLE.
//  Latency: Done rises BIN_W+1 edges after the accepted Start edge (15 for BIN_W=14).
//  Start while Busy==1 is ignored (not queued).
//  Start may assert in the Done cycle; it is accepted because Busy==0 there. Back-to-back throughput is 1 result per BIN_W+1 cycles.
//  Bin changes after capture have no effect on the running conversion.
//  Arithmetic:
//   - Ovf is computed at capture as (Bin > MAX_VAL).
//   - The accumulator is N_DIG*4 bits; bits shifted out of the top digit are discarded, so the raw result = Bin mod 10**N_DIG.
//   - Add-3 is applied before each shift, including the first.
//  BCD holds its last value between conversions (display never blanks).
// CONFIGURATION
//  Macro BIN_TO_BCD_CLAMP_EN. Ovf is produced identically with or without it.
//  Defined: when Ovf==1, FINISH loads all digits with 9 (9999) instead of the raw result.
//  Undefined: when Ovf==1, BCD = Bin mod 10**N_DIG (e.g. 12345 -> 2345).
// STRUCTURE
//  Package bin_to_bcd_pkg holds:
//   - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2
//   - function max_val(N_DIG)
//   - ITER_W = $clog2(BIN_W)
//  Sub-module bcd_add3 is instantiated N_DIG times: combinational 4-bit (d>=5 ? d+3 : d).
//  Top holds the FSM, iteration counter, shift register and output registers.
// TESTING
//  1 Start with Bin=1234 -> Done exactly 15 cycles after accept, BCD=16'h1234, Ovf=0.
//  2 Bin=0 and Bin=9999 -> BCD=16'h0000 and 16'h9999, Ovf=0.
//  3 Bin=12345 -> Ovf=1. With CLAMP_EN BCD=16'h9999; without it BCD=16'h2345.
//  4 Start at cycle 3 of a conversion with a new Bin -> ignored; the first result is unchanged and only one Done pulse occurs.
//  5 RST asserted mid-SHIFT -> next cycle Busy=0, BCD=0, no Done. A fresh Start with Bin=42 -> BCD=16'h0042.
//  6 Start held high continuously, Bin stepping 0..9999 each accept -> one result every 15 cycles; each result matches a reference model.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encodings, default sizing and the decimal full-scale helper.
package bin_to_bcd_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam int DEF_BIN_W = 14;
    localparam int DEF_N_DIG = 4;
    localparam int ITER_W    = $clog2(DEF_BIN_W);

    // Largest value representable in n_dig decimal digits (10**n_dig - 1).
    function automatic int unsigned max_val(input int unsigned n_dig);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n_dig; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = (d >= 4'd5) ? d + 4'd3 : d;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift/add-3 binary-to-BCD converter with a start/busy/done handshake.
// Optional macro BIN_TO_BCD_CLAMP_EN: out-of-range inputs display all nines.
//
// state  | meaning
// IDLE   | waiting for Start, result registers hold the last conversion
// SHIFT  | one add-3 + shift per cycle, BIN_W cycles
// FINISH | publish result and Ovf; a new Start is already accepted here
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W,
    parameter int N_DIG = DEF_N_DIG
) (
    input  logic                 CLK100MHz,
    input  logic                 RST,
    input  logic                 Start,
    input  logic [BIN_W-1:0]     Bin,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Ovf,
    output logic [4*N_DIG-1:0]   BCD
);

    localparam int          ACC_W   = 4 * N_DIG;
    localparam int unsigned MAX_VAL = max_val(N_DIG);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ITER_W-1:0] iter;
    logic [BIN_W-1:0]  shreg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_shf;
    logic [ACC_W-1:0]  result;
    logic              unused_msb;
    logic              ovf_flag;
    logic              done_r;
    logic              accept;
    logic              bin_ovf;

    for (genvar g = 0; g < N_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // The top digit's carry-out is dropped, which yields Bin mod 10**N_DIG.
    always_comb begin
        unused_msb = 1'b0;
        acc_shf    = '0;
        {unused_msb, acc_shf} = {acc_adj, shreg[BIN_W-1]};
    end

    assign bin_ovf = (32'(Bin) > MAX_VAL);

`ifdef BIN_TO_BCD_CLAMP_EN
    assign result = ovf_flag ? {N_DIG{4'h9}} : acc;
`else
    assign result = acc;
`endif

    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = SHIFT;
            SHIFT:   if (iter == '0) state_nxt = FINISH;
            FINISH:  state_nxt = Start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy   = (state == SHIFT);
        Done   = done_r;
        accept = (state != SHIFT) && Start;
    end

    always_ff @(posedge CLK100MHz) begin
        if (RST) begin
            iter     <= '0;
            shreg    <= '0;
            acc      <= '0;
            ovf_flag <= 1'b0;
            done_r   <= 1'b0;
            Ovf      <= 1'b0;
            BCD      <= '0;
        end else begin
            done_r <= (state == FINISH);
            if (state == FINISH) begin
                BCD <= result;
                Ovf <= ovf_flag;
            end
            if (accept) begin
                shreg    <= Bin;
                acc      <= '0;
                iter     <= ITER_W'(BIN_W - 1);
                ovf_flag <= bin_ovf;
            end else if (state == SHIFT) begin
                acc   <= acc_shf;
                shreg <= {shreg[BIN_W-2:0], 1'b0};
                iter  <= iter - 1'b1;
            end
        end
    end

endmodule
